// File: rtl/gray_arb_pkg.sv
// Shared types, defaults and the Gray helper for the converter arbiter.
package gray_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam int DEF_N       = 4;
    localparam int DEF_W       = 4;
    localparam int DEF_TIMEOUT = 15;

    // Reference binary-to-Gray mapping, also used by the bench model.
    function automatic logic [DEF_W-1:0] gray_of(input logic [DEF_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Scan positions ptr+1 .. ptr+N (mod N); the last granted slot gets lowest priority.
    always_comb begin
        int j;
        j      = 0;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = PW'(j);
            end
        end
    end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin sequencer sharing one Gray converter among N requesters,
// with a watchdog that aborts a conversion whose done never arrives.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int W       = DEF_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] req_bin,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_gray,
    output logic           timeout_err,
    output logic           busy,
    output logic           cv_start,
    output logic [W-1:0]   cv_bin,
    input  logic [W-1:0]   cv_gray,
    input  logic           cv_done
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] owner;
    logic [CW-1:0] cnt;

    logic [N-1:0]  pick_oh;
    logic [PW-1:0] pick_idx;
    logic          pick_any;

    rr_pick #(.N(N), .PW(PW)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // busy is a direct decode of the state register, so it is still registered.
    assign busy = (state == ST_WAIT);

    // Grant/sequence FSM with watchdog; pulse outputs default low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= PW'(N - 1);
            owner       <= '0;
            cnt         <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_gray    <= '0;
            timeout_err <= 1'b0;
            cv_start    <= 1'b0;
            cv_bin      <= '0;
        end else begin
            gnt         <= '0;
            cv_start    <= 1'b0;
            rsp_valid   <= '0;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Stray cv_done here is deliberately ignored.
                    if (pick_any) begin
                        gnt      <= pick_oh;
                        cv_start <= 1'b1;
                        cv_bin   <= req_bin[int'(pick_idx)*W +: W];
                        owner    <= pick_idx;
                        ptr      <= pick_idx;
                        cnt      <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    // done takes priority over an expiring watchdog in the same cycle
                    if (cv_done) begin
                        rsp_valid <= N'(1) << owner;
                        rsp_gray  <= cv_gray;
                        state     <= ST_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        rsp_valid   <= N'(1) << owner;
                        rsp_gray    <= '0;
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Self-checking bench: converter stub on cv_* ports, directed plus random requests.
module tb_gray_conv_arbiter;
    import gray_arb_pkg::*;

    localparam int N       = 4;
    localparam int W       = 4;
    localparam int TIMEOUT = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_bin;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_gray, cv_bin, cv_gray;
    logic           timeout_err, busy, cv_start, cv_done;

    logic           hang_cv, stray_done;
    logic           model_done;
    logic [W-1:0]   model_gray, lat_bin;
    int             cd;

    int checks = 0;
    int errors = 0;
    int exp_ptr;

    gray_conv_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_bin     (req_bin),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_gray    (rsp_gray),
        .timeout_err (timeout_err),
        .busy        (busy),
        .cv_start    (cv_start),
        .cv_bin      (cv_bin),
        .cv_gray     (cv_gray),
        .cv_done     (cv_done)
    );

    always #5 clk = ~clk;

    // Converter stand-in: start sampled at edge E, done+result high two edges later for one cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cd <= 0; model_done <= 1'b0; model_gray <= '0; lat_bin <= '0;
        end else begin
            model_done <= 1'b0;
            model_gray <= '0;
            if (cv_start && !hang_cv) begin
                cd <= 2; lat_bin <= cv_bin;
            end else if (cd == 2) begin
                cd <= 1;
            end else if (cd == 1) begin
                cd <= 0; model_done <= 1'b1; model_gray <= gray_of(lat_bin);
            end
        end
    end
    assign cv_done = model_done | stray_done;
    assign cv_gray = model_gray;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full transaction from request to response, checked cycle by cycle.
    task automatic run_conv(input logic [N-1:0] r, input logic [N*W-1:0] ops,
                            input bit hang, input bit keep);
        int idx;
        int lat;
        logic [N-1:0] oh;
        logic [W-1:0] opnd;
        idx = -1;
        for (int k = 1; k <= N; k++) begin
            int j;
            j = (exp_ptr + k) % N;
            if (idx < 0 && r[j]) idx = j;
        end
        oh = '0;
        oh[idx] = 1'b1;
        opnd = ops[idx*W +: W];
        @(negedge clk);
        req = r; req_bin = ops; hang_cv = hang;
        @(posedge clk); #1;
        chk("gnt", gnt, oh);
        chk("cv_start", cv_start, 1);
        chk("cv_bin", cv_bin, opnd);
        chk("busy_grant", busy, 1);
        exp_ptr = idx;
        if (!keep) begin
            @(negedge clk);
            req = r & ~oh;
        end
        lat = hang ? TIMEOUT : 4;
        for (int c = 1; c < lat; c++) begin
            @(posedge clk); #1;
            chk("rsp_early", rsp_valid, 0);
            chk("gnt_in_wait", gnt, 0);
            chk("busy_wait", busy, 1);
        end
        @(posedge clk); #1;
        chk("rsp_valid", rsp_valid, oh);
        chk("rsp_gray", rsp_gray, hang ? '0 : gray_of(opnd));
        chk("timeout_err", timeout_err, hang);
        chk("busy_idle", busy, 0);
        hang_cv = 1'b0;
    endtask

    initial begin
        logic [N-1:0]   r;
        logic [N*W-1:0] ops;
        rst = 1'b1; req = '0; req_bin = '0; hang_cv = 1'b0; stray_done = 1'b0;
        exp_ptr = N - 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs", {gnt, rsp_valid, rsp_gray, timeout_err, busy, cv_start, cv_bin}, 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_no_req", {gnt, busy}, 0);

        // single requester, operand 1011 -> 1110
        run_conv(4'b0001, 16'h000B, 0, 0);
        chk("t1_gray_const", rsp_gray, 4'b1110);

        // all four request, served in order with drop after grant
        ops = {4'd4, 4'd3, 4'd2, 4'd1};
        run_conv(4'b1111, ops, 0, 0);
        run_conv(4'b1110, ops, 0, 0);
        run_conv(4'b1100, ops, 0, 0);
        run_conv(4'b1000, ops, 0, 0);
        chk("t2_last_gray", rsp_gray, 4'd6);

        // req0 and req2 held continuously: strict alternation
        for (int i = 0; i < 4; i++) run_conv(4'b0101, 16'h0905, 0, 1);
        @(negedge clk); req = '0;

        // hung converter on req1, then req0 served normally
        run_conv(4'b0010, 16'h00A0, 1, 0);
        run_conv(4'b0001, 16'h0007, 0, 0);

        // stray done in IDLE must not produce a response
        @(negedge clk); stray_done = 1'b1;
        @(posedge clk); #1;
        chk("stray_rsp", rsp_valid, 0);
        chk("stray_busy", busy, 0);
        @(negedge clk); stray_done = 1'b0;

        // reset mid-conversion
        @(negedge clk); req = 4'b0100; req_bin = 16'h0C00;
        @(posedge clk); #1;
        chk("pre_rst_gnt", gnt, 4'b0100);
        @(negedge clk); req = '0;
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("mid_rst_outs", {gnt, rsp_valid, rsp_gray, timeout_err, busy, cv_start, cv_bin}, 0);
        @(negedge clk); rst = 1'b0;
        exp_ptr = N - 1;
        run_conv(4'b1111, 16'h4321, 0, 0);
        chk("post_rst_first", exp_ptr, 0);
        @(negedge clk); req = '0;

        // operand sweep through requester 3
        for (int b = 0; b < 16; b++) begin
            ops = '0;
            ops[3*W +: W] = W'(b);
            run_conv(4'b1000, ops, 0, 0);
            @(posedge clk); #1;
            chk("sweep_idle_busy", busy, 0);
        end

        // random traffic with occasional idle gaps
        for (int i = 0; i < 24; i++) begin
            r   = N'($urandom_range(1, (1 << N) - 1));
            ops = N*W'($urandom);
            run_conv(r, ops, 0, bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) begin
                @(negedge clk); req = '0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                chk("gap_idle", {gnt, busy}, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL global_timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
